// File: rtl/branch_verify.sv
// EX-stage branch verification: resolves each branch, checks it against the
// fetch-time prediction and tracks mispredict recovery. Optional statistics
// counters are enabled by defining BRANCH_VERIFY_STAT_EN.

package branch_verify_pkg;

  localparam logic [2:0] B_IS_NONE = 3'd0;
  localparam logic [2:0] B_IS_CALL = 3'd1;
  localparam logic [2:0] B_IS_RET  = 3'd2;
  localparam logic [2:0] B_IS_BRA  = 3'd3;
  localparam logic [2:0] B_IS_J    = 3'd4;

  localparam logic [2:0] C_BEQ  = 3'd0;
  localparam logic [2:0] C_BNE  = 3'd1;
  localparam logic [2:0] C_BGEZ = 3'd2;
  localparam logic [2:0] C_BGTZ = 3'd3;
  localparam logic [2:0] C_BLEZ = 3'd4;
  localparam logic [2:0] C_BLTZ = 3'd5;

  typedef struct packed {
    logic ex;
    logic eret;
    logic tlb_op;
  } pipeline_flush_t;

  typedef struct packed {
    logic        valid;
    logic [2:0]  br_op;
    logic        br_taken;
    logic [31:0] target;
  } predict_result_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] counter;
    logic [7:0] tag;
  } BHT_entry_t;

  typedef struct packed {
    logic        ready;
    logic [2:0]  br_type;
    logic [31:0] pc;
    logic        is_taken;
    logic        predict_sucess;
    logic [31:0] correct_target;
    BHT_entry_t  predict_entry;
  } verify_result_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_DS = 2'd1,
    S_CORRECT = 2'd2
  } state_e;

endpackage

module branch_verify
  import branch_verify_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  pipeline_flush_t pipeline_flush,
  input  logic            in_valid,
  input  logic [31:0]     in_pc,
  input  logic [2:0]      in_br_type,
  input  logic [2:0]      in_br_cond,
  input  logic            in_use_reg,
  input  logic [31:0]     rs_value,
  input  logic [31:0]     rt_value,
  input  logic [31:0]     imm_target,
  input  logic [31:0]     reg_target,
  input  predict_result_t pred_bus,
  input  BHT_entry_t      pred_entry,
  output verify_result_t  es_to_bpu_bus,
  input  logic            correct_finish,
  output logic            wrong_path
`ifdef BRANCH_VERIFY_STAT_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  state_e         state_q, state_d;
  verify_result_t bus_q, bus_d;

  logic        flush_any;
  logic        act_taken;
  logic [31:0] act_target;
  logic [31:0] fallthrough;
  logic        pred_ok;
  logic        report;
  logic        unused_pred_op;

  assign flush_any      = pipeline_flush.ex | pipeline_flush.eret | pipeline_flush.tlb_op;
  assign unused_pred_op = ^pred_bus.br_op;

  always_comb begin : resolve
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    act_taken  = 1'b0;
    act_target = imm_target;
    case (in_br_type)
      B_IS_BRA: begin
        case (in_br_cond)
          C_BEQ:   act_taken = (rs_value == rt_value);
          C_BNE:   act_taken = (rs_value != rt_value);
          C_BGEZ:  act_taken = ($signed(rs_value) >= 32'sd0);
          C_BGTZ:  act_taken = ($signed(rs_value) >  32'sd0);
          C_BLEZ:  act_taken = ($signed(rs_value) <= 32'sd0);
          C_BLTZ:  act_taken = ($signed(rs_value) <  32'sd0);
          default: act_taken = 1'b0;
        endcase
      end
      B_IS_CALL, B_IS_J: begin
        act_taken  = 1'b1;
        act_target = in_use_reg ? reg_target : imm_target;
      end
      B_IS_RET: begin
        act_taken  = 1'b1;
        act_target = reg_target;
      end
      default: ;
    endcase
  end

  assign fallthrough = in_pc + 32'd8;

  // A not-taken branch is correct whenever direction matches; target only matters when taken.
  assign pred_ok = (pred_bus.valid && (pred_bus.br_taken == act_taken) &&
                    (!act_taken || (pred_bus.target == act_target))) ||
                   (!pred_bus.valid && !act_taken);

  assign report = in_valid && (in_br_type != B_IS_NONE) && (state_q == S_IDLE) && !flush_any;

  always_comb begin : next_state
    state_d       = state_q;
    bus_d         = bus_q;
    bus_d.ready   = 1'b0;
    bus_d.br_type = B_IS_NONE;

    if (report) begin
      bus_d.ready          = 1'b1;
      bus_d.br_type        = in_br_type;
      bus_d.pc             = in_pc;
      bus_d.is_taken       = act_taken;
      bus_d.predict_sucess = pred_ok;
      bus_d.correct_target = act_taken ? act_target : fallthrough;
      bus_d.predict_entry  = pred_entry;
    end

    if (flush_any) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (report && !pred_ok) state_d = S_WAIT_DS;
        S_WAIT_DS: if (in_valid)           state_d = S_CORRECT;
        S_CORRECT: if (correct_finish)     state_d = S_IDLE;
        default:                           state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!resetn) begin
      state_q <= S_IDLE;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
    end
  end

  assign es_to_bpu_bus = bus_q;
  // Combinational on purpose: it qualifies the instruction sitting in EX this cycle.
  assign wrong_path    = in_valid && (state_q == S_CORRECT);

`ifdef BRANCH_VERIFY_STAT_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin : stat_next
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (report && (stat_branches_q != '1)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (report && !pred_ok && (stat_mispredicts_q != '1)) begin
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_verify.sv
// Scoreboard bench for branch_verify: the driver queues hand-computed results,
// a monitor compares them whenever the bus reports ready.

module tb_branch_verify;
  import branch_verify_pkg::*;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_EX   = 3'b100;
  localparam logic [2:0] F_ERET = 3'b010;
  localparam logic [2:0] F_TLB  = 3'b001;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  pipeline_flush_t pipeline_flush;
  logic            in_valid;
  logic [31:0]     in_pc;
  logic [2:0]      in_br_type;
  logic [2:0]      in_br_cond;
  logic            in_use_reg;
  logic [31:0]     rs_value, rt_value, imm_target, reg_target;
  predict_result_t pred_bus;
  BHT_entry_t      pred_entry;
  verify_result_t  es_to_bpu_bus;
  logic            correct_finish;
  logic            wrong_path;
`ifdef BRANCH_VERIFY_STAT_EN
  logic [31:0]     stat_branches, stat_mispredicts;
`endif

  branch_verify dut (
    .clk            (clk),
    .resetn         (resetn),
    .pipeline_flush (pipeline_flush),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_br_type     (in_br_type),
    .in_br_cond     (in_br_cond),
    .in_use_reg     (in_use_reg),
    .rs_value       (rs_value),
    .rt_value       (rt_value),
    .imm_target     (imm_target),
    .reg_target     (reg_target),
    .pred_bus       (pred_bus),
    .pred_entry     (pred_entry),
    .es_to_bpu_bus  (es_to_bpu_bus),
    .correct_finish (correct_finish),
    .wrong_path     (wrong_path)
`ifdef BRANCH_VERIFY_STAT_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  verify_result_t exp_q[$];
  verify_result_t last_exp = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] ty, input logic [2:0] fl, input logic cf);
    in_valid       = v;
    in_br_type     = ty;
    pipeline_flush = pipeline_flush_t'(fl);
    correct_finish = cf;
  endtask

  // One non-verified cycle: drive control inputs, then check wrong_path for this instruction.
  task automatic step(input string name, input logic v, input logic [2:0] ty,
                      input logic [2:0] fl, input logic cf, input logic e_wp);
    @(negedge clk);
    drive(v, ty, fl, cf);
    #1 check(name, 128'(wrong_path), 128'(e_wp));
  endtask

  // One branch cycle; when rep=1 the hand-computed bus contents are queued.
  task automatic br(input string name, input logic [31:0] pc, input logic [2:0] ty,
                    input logic [2:0] cond, input logic use_reg,
                    input logic [31:0] rs, input logic [31:0] rt,
                    input logic [31:0] imm, input logic [31:0] rg,
                    input logic pv, input logic pt, input logic [31:0] ptgt,
                    input logic [2:0] fl, input logic rep,
                    input logic e_taken, input logic e_succ, input logic [31:0] e_tgt);
    verify_result_t e;
    @(negedge clk);
    drive(1'b1, ty, fl, 1'b0);
    in_pc              = pc;
    in_br_cond         = cond;
    in_use_reg         = use_reg;
    rs_value           = rs;
    rt_value           = rt;
    imm_target         = imm;
    reg_target         = rg;
    pred_bus.valid     = pv;
    pred_bus.br_op     = ty;
    pred_bus.br_taken  = pt;
    pred_bus.target    = ptgt;
    pred_entry.valid   = 1'b1;
    pred_entry.counter = pc[3:2];
    pred_entry.tag     = pc[11:4];
    if (rep) begin
      e                = '0;
      e.ready          = 1'b1;
      e.br_type        = ty;
      e.pc             = pc;
      e.is_taken       = e_taken;
      e.predict_sucess = e_succ;
      e.correct_target = e_tgt;
      e.predict_entry  = pred_entry;
      exp_q.push_back(e);
    end
    #1 check({name, "_wp"}, 128'(wrong_path), 128'(0));
  endtask

  // Monitor: compares every report against the queue, and idle cycles against held fields.
  initial begin
    verify_result_t hold;
    forever begin
      @(posedge clk);
      #1;
      if (resetn) begin
        if (es_to_bpu_bus.ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_report actual=%0h required=no report", es_to_bpu_bus);
          end else begin
            last_exp = exp_q.pop_front();
            check("report", 128'(es_to_bpu_bus), 128'(last_exp));
          end
        end else begin
          hold         = last_exp;
          hold.ready   = 1'b0;
          hold.br_type = B_IS_NONE;
          check("idle_bus", 128'(es_to_bpu_bus), 128'(hold));
        end
      end
    end
  end

  always @(negedge resetn) last_exp = '0;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b1, B_IS_NONE, F_NONE, 1'b0);
    in_pc = '0; in_br_cond = '0; in_use_reg = 1'b0;
    rs_value = '0; rt_value = '0; imm_target = '0; reg_target = '0;
    pred_bus = '0; pred_entry = '0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_bus", 128'(es_to_bpu_bus), 128'(0));
    check("reset_wp", 128'(wrong_path), 128'(0));
    @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, B_IS_NONE, F_NONE, 1'b0);

    // Correct predictions: each must report and leave the FSM in IDLE.
    br("beq_hit",  32'h8000_1000, B_IS_BRA, C_BEQ, 1'b0, 32'd5, 32'd5, 32'h8000_1040, 32'h0,
       1'b1, 1'b1, 32'h8000_1040, F_NONE, 1'b1, 1'b1, 1'b1, 32'h8000_1040);
    br("j_imm",    32'h8000_1010, B_IS_J, 3'd0, 1'b0, 32'h0, 32'h0, 32'h8000_3000, 32'h8000_9990,
       1'b1, 1'b1, 32'h8000_3000, F_NONE, 1'b1, 1'b1, 1'b1, 32'h8000_3000);
    br("call_reg", 32'h8000_1014, B_IS_CALL, 3'd0, 1'b1, 32'h0, 32'h0, 32'h8000_5000, 32'h8000_4000,
       1'b1, 1'b1, 32'h8000_4000, F_NONE, 1'b1, 1'b1, 1'b1, 32'h8000_4000);
    br("bgtz_zero", 32'h8000_1020, B_IS_BRA, C_BGTZ, 1'b0, 32'h0, 32'h0, 32'h8000_1080, 32'h0,
       1'b1, 1'b0, 32'h1234_5678, F_NONE, 1'b1, 1'b0, 1'b1, 32'h8000_1028);
    br("blez_neg", 32'h8000_1030, B_IS_BRA, C_BLEZ, 1'b0, 32'h8000_0000, 32'h0, 32'h8000_0f00, 32'h0,
       1'b1, 1'b1, 32'h8000_0f00, F_NONE, 1'b1, 1'b1, 1'b1, 32'h8000_0f00);
    br("bgtz_max", 32'h8000_1040, B_IS_BRA, C_BGTZ, 1'b0, 32'h7fff_ffff, 32'h0, 32'h8000_0200, 32'h0,
       1'b1, 1'b1, 32'h8000_0200, F_NONE, 1'b1, 1'b1, 1'b1, 32'h8000_0200);
    br("never_wrap", 32'hffff_fffc, B_IS_BRA, 3'd6, 1'b0, 32'h1, 32'h1, 32'h0000_0100, 32'h0,
       1'b0, 1'b0, 32'h0, F_NONE, 1'b1, 1'b0, 1'b1, 32'h0000_0004);
    step("idle_nonbranch", 1'b1, B_IS_NONE, F_NONE, 1'b0, 1'b0);

    // bne mispredict: delay slot (even a branch) runs, then wrong path until correct_finish.
    br("bne_miss", 32'h8000_1000, B_IS_BRA, C_BNE, 1'b0, 32'd7, 32'd7, 32'h8000_1040, 32'h0,
       1'b1, 1'b1, 32'h8000_1040, F_NONE, 1'b1, 1'b0, 1'b0, 32'h8000_1008);
    step("ds_branch",  1'b1, B_IS_BRA,  F_NONE, 1'b0, 1'b0);
    step("wp_instr",   1'b1, B_IS_NONE, F_NONE, 1'b0, 1'b1);
    step("wp_bubble",  1'b0, B_IS_NONE, F_NONE, 1'b0, 1'b0);
    step("wp_call",    1'b1, B_IS_CALL, F_NONE, 1'b0, 1'b1);
    step("finish",     1'b0, B_IS_NONE, F_NONE, 1'b1, 1'b0);
    br("after_fin", 32'h8000_1200, B_IS_BRA, C_BEQ, 1'b0, 32'd1, 32'd2, 32'h8000_1300, 32'h0,
       1'b1, 1'b0, 32'h0, F_NONE, 1'b1, 1'b0, 1'b1, 32'h8000_1208);

    // RET target mismatch; early correct_finish ignored; flush beats correct_finish.
    br("ret_miss", 32'h8000_1100, B_IS_RET, 3'd0, 1'b0, 32'h0, 32'h0, 32'h8000_7000, 32'h8000_2000,
       1'b1, 1'b1, 32'h8000_2004, F_NONE, 1'b1, 1'b1, 1'b0, 32'h8000_2000);
    step("cf_in_wait", 1'b0, B_IS_NONE, F_NONE, 1'b1, 1'b0);
    step("ret_ds",     1'b1, B_IS_NONE, F_NONE, 1'b0, 1'b0);
    step("ret_wp",     1'b1, B_IS_NONE, F_NONE, 1'b0, 1'b1);
    step("flush_cf",   1'b1, B_IS_BRA,  F_EX,   1'b1, 1'b1);
    step("post_flush", 1'b1, B_IS_NONE, F_NONE, 1'b0, 1'b0);

    // Invalid prediction: taken bltz mispredicts, not-taken bltz is correct.
    br("bltz_neg", 32'h8000_1300, B_IS_BRA, C_BLTZ, 1'b0, 32'hffff_ffff, 32'h0, 32'h8000_1500, 32'h0,
       1'b0, 1'b0, 32'h0, F_NONE, 1'b1, 1'b1, 1'b0, 32'h8000_1500);
    step("eret_flush", 1'b1, B_IS_BRA, F_ERET, 1'b0, 1'b0);
    br("bltz_zero", 32'h8000_1310, B_IS_BRA, C_BLTZ, 1'b0, 32'h0, 32'h0, 32'h8000_1500, 32'h0,
       1'b0, 1'b0, 32'h0, F_NONE, 1'b1, 1'b0, 1'b1, 32'h8000_1318);

    // A flush in the same cycle suppresses the report and the pending mispredict.
    br("tlb_block", 32'h8000_1400, B_IS_BRA, C_BEQ, 1'b0, 32'd3, 32'd3, 32'h8000_1480, 32'h0,
       1'b1, 1'b0, 32'h0, F_TLB, 1'b0, 1'b0, 1'b0, 32'h0);
    br("after_tlb", 32'h8000_1410, B_IS_J, 3'd0, 1'b0, 32'h0, 32'h0, 32'h8000_1800, 32'h0,
       1'b1, 1'b1, 32'h8000_1800, F_NONE, 1'b1, 1'b1, 1'b1, 32'h8000_1800);

    // Asynchronous reset while waiting for the delay slot.
    br("bgez_miss", 32'h8000_1500, B_IS_BRA, C_BGEZ, 1'b0, 32'd1, 32'd0, 32'h8000_1600, 32'h0,
       1'b1, 1'b0, 32'h0, F_NONE, 1'b1, 1'b1, 1'b0, 32'h8000_1600);
    @(negedge clk);
    drive(1'b1, B_IS_NONE, F_NONE, 1'b0);
    resetn = 1'b0;
    #1;
    check("async_rst_bus", 128'(es_to_bpu_bus), 128'(0));
    check("async_rst_wp", 128'(wrong_path), 128'(0));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    drive(1'b0, B_IS_NONE, F_NONE, 1'b0);
    step("rst_idle1", 1'b1, B_IS_NONE, F_NONE, 1'b0, 1'b0);
    step("rst_idle2", 1'b1, B_IS_NONE, F_NONE, 1'b0, 1'b0);

`ifdef BRANCH_VERIFY_STAT_EN
    check("stat_br_rst", 128'(stat_branches), 128'(0));
    check("stat_mp_rst", 128'(stat_mispredicts), 128'(0));
    br("st_ok",  32'h8000_2000, B_IS_J, 3'd0, 1'b0, 32'h0, 32'h0, 32'h8000_2100, 32'h0,
       1'b1, 1'b1, 32'h8000_2100, F_NONE, 1'b1, 1'b1, 1'b1, 32'h8000_2100);
    br("st_bad", 32'h8000_2010, B_IS_J, 3'd0, 1'b0, 32'h0, 32'h0, 32'h8000_2200, 32'h0,
       1'b1, 1'b1, 32'h8000_2204, F_NONE, 1'b1, 1'b1, 1'b0, 32'h8000_2200);
    step("st_flush", 1'b0, B_IS_NONE, F_EX, 1'b0, 1'b0);
    check("stat_br_cnt", 128'(stat_branches), 128'(2));
    check("stat_mp_cnt", 128'(stat_mispredicts), 128'(1));
    force dut.stat_branches_q = '1;
    force dut.stat_mispredicts_q = '1;
    @(negedge clk);
    release dut.stat_branches_q;
    release dut.stat_mispredicts_q;
    br("st_sat", 32'h8000_2020, B_IS_J, 3'd0, 1'b0, 32'h0, 32'h0, 32'h8000_2300, 32'h0,
       1'b1, 1'b1, 32'h8000_2304, F_NONE, 1'b1, 1'b1, 1'b0, 32'h8000_2300);
    step("st_flush2", 1'b0, B_IS_NONE, F_EX, 1'b0, 1'b0);
    check("stat_br_sat", 128'(stat_branches), 128'(32'hffff_ffff));
    check("stat_mp_sat", 128'(stat_mispredicts), 128'(32'hffff_ffff));
`endif

    repeat (3) step("drain", 1'b0, B_IS_NONE, F_NONE, 1'b0, 1'b0);
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_verify.md
BRANCH_VERIFY -- requirements
Module: branch_verify

Interface
REQ-001 clk  input  1  core clock; all state updates on its rising edge.
REQ-002 resetn  input  1  reset, asynchronous and active-low.
REQ-003 pipeline_flush  input  pipeline_flush_t  only the ex, eret and tlb_op fields are used.
REQ-004 in_valid  input  1  EX-stage instruction valid this cycle; no backpressure is applied.
REQ-005 in_pc  input  32  PC of the EX instruction.
REQ-006 in_br_type  input  3  branch class: 0 = none, plus B_IS_CALL, B_IS_RET, B_IS_BRA, B_IS_J.
REQ-007 in_br_cond  input  3  BRA condition: 0 beq, 1 bne, 2 bgez, 3 bgtz, 4 blez, 5 bltz; 6 and 7 mean never taken.
REQ-008 in_use_reg  input  1  for CALL/J, selects reg_target (jalr/jr) instead of imm_target.
REQ-009 rs_value, rt_value  input  32 each  forwarded operands.
REQ-010 imm_target, reg_target  input  32 each  precomputed immediate and register targets.
REQ-011 pred_bus  input  predict_result_t  prediction that travelled with the instruction (valid, br_op, br_taken, target).
REQ-012 pred_entry  input  BHT_entry_t  BHT entry read at fetch.
REQ-013 es_to_bpu_bus  output  verify_result_t  registered verify result to the BPU.
REQ-014 correct_finish  input  1  fetch has taken the redirect.
REQ-015 wrong_path  output  1  current in_valid instruction is on the mispredicted path and must be killed.

Function
REQ-016 Actual outcome: BRA is taken per in_br_cond, using signed compares of rs (beq/bne compare rs with rt); CALL, J and RET are always taken.
REQ-017 Actual target: BRA uses imm_target; CALL and J use reg_target when in_use_reg=1, else imm_target; RET uses reg_target.
REQ-018 predict_sucess=1 when any of these holds: pred valid and taken equal to actual taken, and (actual not taken, or pred target equal to actual target); or pred invalid and actual not taken.
REQ-019 The correct_target field is the actual target if taken, else in_pc+8 (32-bit wrap).
REQ-020 Latency 1: inputs sampled with in_valid=1, in_br_type!=0, state IDLE and no flush appear on es_to_bpu_bus the next cycle with ready=1.
REQ-021 Bus contents: br_type, pc, is_taken, predict_sucess, correct_target; predict_entry is pred_entry unmodified.
REQ-022 In every other cycle the bus has ready=0 and br_type=0; its remaining fields hold their last values.
REQ-023 The FSM has three states: IDLE, WAIT_DS, CORRECT.
REQ-024 In IDLE, a reported mispredict moves to WAIT_DS in the same edge that registers the result; a correct prediction stays in IDLE.
REQ-025 In WAIT_DS, the first in_valid instruction is the delay slot; it executes normally (wrong_path=0), is never verified, and moves the FSM to CORRECT.
REQ-026 In CORRECT, wrong_path=in_valid and no branch is verified; correct_finish=1 returns the FSM to IDLE.
REQ-027 A correct_finish seen in IDLE or WAIT_DS is ignored.
REQ-028 wrong_path is 0 in IDLE and WAIT_DS.
REQ-029 pipeline_flush.ex, .eret or .tlb_op forces IDLE and ready=0 next cycle and overrides every other event the same cycle, including a pending mispredict.
REQ-030 A branch in the delay slot position (WAIT_DS) is treated as a plain delay slot and is not verified.

Reset
REQ-031 While resetn=0 the state is IDLE, es_to_bpu_bus is all zeros, wrong_path=0, and the statistics counters are 0.
REQ-032 Assertion of resetn=0 mid-operation (including WAIT_DS or CORRECT) takes effect immediately and asynchronously.
REQ-033 Release of resetn is synchronised by the integrator; this block adds no synchroniser.

Configuration
REQ-034 Macro BRANCH_VERIFY_STAT_EN defined: the block adds outputs stat_branches and stat_mispredicts (32 bits each, saturating at 0xFFFFFFFF). stat_branches increments per reported branch; stat_mispredicts increments per reported mispredict. Both are cleared only by reset.
REQ-035 Macro BRANCH_VERIFY_STAT_EN undefined: those ports and counters do not exist, and all other behaviour is identical.

Verification
REQ-036 beq, rs=rt=5, pc=0x80001000, imm_target=0x80001040, pred taken with target 0x80001040 -> next cycle ready=1, is_taken=1, predict_sucess=1; state stays IDLE.
REQ-037 bne, rs=rt, pred taken -> predict_sucess=0, correct_target=0x80001008, state WAIT_DS; the next valid instruction gives wrong_path=0, the following ones give wrong_path=1 until correct_finish.
REQ-038 RET, reg_target=0x80002000, pred target 0x80002004 -> predict_sucess=0, correct_target=0x80002000.
REQ-039 In CORRECT, pipeline_flush.ex and correct_finish asserted together -> IDLE, ready=0 next cycle, wrong_path=0.
REQ-040 pred invalid, bltz with rs=0xFFFFFFFF -> taken, predict_sucess=0; with rs=0 -> not taken, predict_sucess=1.
REQ-041 resetn low during WAIT_DS -> immediate IDLE and bus zero; with BRANCH_VERIFY_STAT_EN, counters preset to 0xFFFFFFFF stay saturated after a further branch.
